// File: rtl/parity_gen.sv
// ============================================================================
//  Module      : parity_gen
//  Description : Serial 3-bit frame parity generator (Moore FSM, registered z).
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module parity_gen #(
  parameter bit ODD_PARITY = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic w,
  output logic z
);

  // Suffix E/O is the running parity of the bits collected so far in the frame.
  localparam logic [2:0] c_s0  = 3'd0;
  localparam logic [2:0] c_s1e = 3'd1;
  localparam logic [2:0] c_s1o = 3'd2;
  localparam logic [2:0] c_s2e = 3'd3;
  localparam logic [2:0] c_s2o = 3'd4;
  localparam logic [2:0] c_s3e = 3'd5;
  localparam logic [2:0] c_s3o = 3'd6;

  logic [2:0] r_state;
  logic [2:0] w_next;
  logic       w_z_next;
  logic       r_z;

  always_comb begin
    w_next = c_s0;
    case (r_state)
      c_s0, c_s3e, c_s3o: w_next = w ? c_s1o : c_s1e;
      c_s1e:              w_next = w ? c_s2o : c_s2e;
      c_s1o:              w_next = w ? c_s2e : c_s2o;
      c_s2e:              w_next = w ? c_s3o : c_s3e;
      c_s2o:              w_next = w ? c_s3e : c_s3o;
      default:            w_next = c_s0;
    endcase
  end

  // z is registered from the next state so it lines up with the S3 cycle.
  always_comb begin
    w_z_next = 1'b0;
    case (w_next)
      c_s3e:   w_z_next = ODD_PARITY;
      c_s3o:   w_z_next = ~ODD_PARITY;
      default: w_z_next = 1'b0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= c_s0;
      r_z     <= 1'b0;
    end else begin
      r_state <= w_next;
      r_z     <= w_z_next;
    end
  end

  assign z = r_z;

endmodule

`default_nettype wire

// File: tb/tb_parity_gen.sv
// ============================================================================
//  Module      : tb_parity_gen
//  Description : Self-checking bench for parity_gen, both parity senses.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_parity_gen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic w   = 1'b0;
  logic z_even;
  logic z_odd;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  parity_gen #(.ODD_PARITY(1'b0)) dut_even (
    .clk (clk),
    .rst (rst),
    .w   (w),
    .z   (z_even)
  );

  parity_gen #(.ODD_PARITY(1'b1)) dut_odd (
    .clk (clk),
    .rst (rst),
    .w   (w),
    .z   (z_odd)
  );

  // Reference: collect bits of the current frame, emit parity once three arrive.
  bit   frame_q[$];
  logic exp_even = 1'b0;
  logic exp_odd  = 1'b0;
  bit   armed    = 1'b0;

  always @(posedge clk) begin
    if (rst === 1'b1) begin
      frame_q.delete();
      exp_even = 1'b0;
      exp_odd  = 1'b0;
      armed    = 1'b1;
    end else begin
      frame_q.push_back(w);
      if (frame_q.size() == 3) begin
        int ones;
        ones = int'(frame_q[0]) + int'(frame_q[1]) + int'(frame_q[2]);
        exp_even = ((ones % 2) == 1);
        exp_odd  = ((ones % 2) == 0);
        frame_q.delete();
      end else begin
        exp_even = 1'b0;
        exp_odd  = 1'b0;
      end
    end
  end

  always @(negedge clk) begin
    if (armed) begin
      total++;
      if (z_even !== exp_even) begin
        bad++;
        $display("FAIL model_even t=%0t got=%b want=%b", $time, z_even, exp_even);
      end
      total++;
      if (z_odd !== exp_odd) begin
        bad++;
        $display("FAIL model_odd t=%0t got=%b want=%b", $time, z_odd, exp_odd);
      end
    end
  end

  // One edge of stimulus, then literal check of both outputs just after it.
  task automatic step(input logic r, input logic b, input logic e_even,
                      input logic e_odd, input string name);
    @(negedge clk);
    rst = r;
    w   = b;
    @(posedge clk);
    #1;
    total++;
    if (z_even !== e_even) begin
      bad++;
      $display("FAIL %s even got=%b want=%b", name, z_even, e_even);
    end
    total++;
    if (z_odd !== e_odd) begin
      bad++;
      $display("FAIL %s odd got=%b want=%b", name, z_odd, e_odd);
    end
  endtask

  initial begin
    // Reset with w undriven-like X.
    step(1'b1, 1'bx, 1'b0, 1'b0, "rst_a");
    step(1'b1, 1'bx, 1'b0, 1'b0, "rst_b");

    // 1,0,1 -> even count of ones; then 1,0,0 -> odd.
    step(1'b0, 1'b1, 1'b0, 1'b0, "f1_b1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "f1_b2");
    step(1'b0, 1'b1, 1'b0, 1'b1, "f1_b3");
    step(1'b0, 1'b1, 1'b0, 1'b0, "f2_b1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "f2_b2");
    step(1'b0, 1'b0, 1'b1, 1'b0, "f2_b3");

    // 1,1,0 then 1,0,1 back to back.
    step(1'b0, 1'b1, 1'b0, 1'b0, "f3_b1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "f3_b2");
    step(1'b0, 1'b0, 1'b0, 1'b1, "f3_b3");
    step(1'b0, 1'b1, 1'b0, 1'b0, "f4_b1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "f4_b2");
    step(1'b0, 1'b1, 1'b0, 1'b1, "f4_b3");

    // 1,1,1 -> one-cycle pulse; then 0,0,0.
    step(1'b0, 1'b1, 1'b0, 1'b0, "f5_b1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "f5_b2");
    step(1'b0, 1'b1, 1'b1, 1'b0, "f5_b3");
    step(1'b0, 1'b0, 1'b0, 1'b0, "f6_b1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "f6_b2");
    step(1'b0, 1'b0, 1'b0, 1'b1, "f6_b3");

    // Partial frame 1,1 discarded by reset, then 1,0,0.
    step(1'b0, 1'b1, 1'b0, 1'b0, "mid_p1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "mid_p2");
    step(1'b1, 1'b1, 1'b0, 1'b0, "mid_rst");
    step(1'b0, 1'b1, 1'b0, 1'b0, "mid_b1");
    step(1'b0, 1'b0, 1'b0, 1'b0, "mid_b2");
    step(1'b0, 1'b0, 1'b1, 1'b0, "mid_b3");

    // Reset right at frame completion clears the pulse.
    step(1'b0, 1'b0, 1'b0, 1'b0, "end_b1");
    step(1'b0, 1'b1, 1'b0, 1'b0, "end_b2");
    step(1'b1, 1'b1, 1'b0, 1'b0, "end_rst");
    step(1'b0, 1'b0, 1'b0, 1'b0, "end_after");

    @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire
